// File: rtl/wb_cfg_stream_loader.sv
// Wishbone-fed eFPGA bitstream loader: FIFO-buffered words shifted MSB-first onto the config chain.
// Optional CRC-16/CCITT over the shifted bits is built when CFG_CRC_EN is defined.
module wb_cfg_stream_loader #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          BIT_DIV    = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cfg_sdo,
  output logic        cfg_sen,
  output logic        cfg_latch,
  output logic        cfg_done
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_LATCH} state_t;

  state_t        state_q, state_d;
  logic          ack_q, ack_d, wr_q, wr_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [2:0]    off_q;
  logic [31:0]   wdat_q;
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [31:0]   sr_q, sr_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sdo_q, sdo_d, sen_q, sen_d, latch_q, latch_d, done_q, done_d;
  logic          ovf_q, ovf_d, end_req_q, end_req_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [15:0]   crc_q, crc_d;

  logic          sel, req, do_wr, start, abort, end_wr, push_req, push_ok, pop;
  logic          empty, full;
  logic [AW:0]   level;
  logic [31:0]   level32, stat, crc_rd, head;
  logic          unused_adr_bits;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign unused_adr_bits = ^wbs_adr_i[1:0];

  always_comb begin
    sel      = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    req      = sel & wbs_stb_i & wbs_cyc_i & ~ack_q;
    level    = wptr_q - rptr_q;
    level32  = 32'(level);
    empty    = (level == '0);
    full     = (level == (AW+1)'(FIFO_DEPTH));
    head     = mem[rptr_q[AW-1:0]];
`ifdef CFG_CRC_EN
    crc_rd   = {16'h0, crc_q};
`else
    crc_rd   = 32'h0;
`endif
    stat     = {16'h0, level32[7:0], 3'b0, ovf_q, done_q, empty, full, (state_q != S_IDLE)};

    // Writes captured on the request cycle take effect on the ack cycle.
    do_wr    = ack_q & wr_q;
    start    = do_wr & (off_q == 3'd0) & wdat_q[0];
    abort    = do_wr & (off_q == 3'd0) & wdat_q[1];
    end_wr   = do_wr & (off_q == 3'd0) & wdat_q[2];
    push_req = do_wr & (off_q == 3'd2);
    pop      = (state_q == S_WAIT) & ~empty;
    push_ok  = push_req & (~full | pop);

    ack_d    = req;
    wr_d     = req & wbs_we_i;
    rdat_d   = 32'h0;
    if (req && !wbs_we_i) begin
      case (wbs_adr_i[4:2])
        3'd1:    rdat_d = stat;
        3'd3:    rdat_d = {16'h0, word_cnt_q};
        3'd4:    rdat_d = crc_rd;
        default: rdat_d = 32'h0;
      endcase
    end

    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    sdo_d      = sdo_q;
    sen_d      = sen_q;
    latch_d    = 1'b0;
    done_d     = done_q;
    ovf_d      = ovf_q | (push_req & full & ~pop);
    end_req_d  = end_req_q;
    word_cnt_d = word_cnt_q;
    crc_d      = crc_q;
    wptr_d     = wptr_q + (AW+1)'(push_ok);
    rptr_d     = rptr_q + (AW+1)'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT;
          word_cnt_d = 16'h0;
          ovf_d      = 1'b0;
          end_req_d  = 1'b0;
          done_d     = 1'b0;
          crc_d      = 16'hFFFF;
        end
      end
      S_WAIT: begin
        if (pop) begin
          state_d   = S_SHIFT;
          sr_d      = head;
          sdo_d     = head[31];
          sen_d     = 1'b1;
          bit_cnt_d = 5'd0;
          div_cnt_d = '0;
        end else if (end_req_q) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          end_req_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (div_cnt_q == DW'(BIT_DIV - 1)) begin
          div_cnt_d = '0;
          crc_d     = crc_step(crc_q, sdo_q);
          if (bit_cnt_q == 5'd31) begin
            state_d = S_LATCH;
            sen_d   = 1'b0;
            sdo_d   = 1'b0;
            latch_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            sr_d      = {sr_q[30:0], 1'b0};
            sdo_d     = sr_q[30];
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      S_LATCH: begin
        state_d    = S_WAIT;
        word_cnt_d = word_cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (end_wr) end_req_d = 1'b1;

    // Abort overrides everything, including a START in the same write.
    if (abort) begin
      state_d   = S_IDLE;
      sen_d     = 1'b0;
      sdo_d     = 1'b0;
      latch_d   = 1'b0;
      end_req_d = 1'b0;
      done_d    = done_q;
      rptr_d    = wptr_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      wr_q       <= 1'b0;
      rdat_q     <= 32'h0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      bit_cnt_q  <= 5'd0;
      div_cnt_q  <= '0;
      sdo_q      <= 1'b0;
      sen_q      <= 1'b0;
      latch_q    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      end_req_q  <= 1'b0;
      word_cnt_q <= 16'h0;
      crc_q      <= 16'hFFFF;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      wr_q       <= wr_d;
      rdat_q     <= rdat_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      sdo_q      <= sdo_d;
      sen_q      <= sen_d;
      latch_q    <= latch_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      end_req_q  <= end_req_d;
      word_cnt_q <= word_cnt_d;
      crc_q      <= crc_d;
    end
  end

  // Datapath storage carries no reset; control flops above qualify it.
  always_ff @(posedge wb_clk_i) begin
    sr_q <= sr_d;
    if (req) begin
      off_q  <= wbs_adr_i[4:2];
      wdat_q <= wbs_dat_i;
    end
    if (push_ok) mem[wptr_q[AW-1:0]] <= wdat_q;
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign cfg_sdo   = sdo_q;
  assign cfg_sen   = sen_q;
  assign cfg_latch = latch_q;
  assign cfg_done  = done_q;
endmodule

// File: tb/tb_wb_cfg_stream_loader.sv
// Directed bench for wb_cfg_stream_loader (FIFO_DEPTH=16, BIT_DIV=1); CRC expectation follows CFG_CRC_EN.
module tb_wb_cfg_stream_loader;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] CTRL  = BASE + 32'h00;
  localparam logic [31:0] STAT  = BASE + 32'h04;
  localparam logic [31:0] DATA  = BASE + 32'h08;
  localparam logic [31:0] WCNT  = BASE + 32'h0C;
  localparam logic [31:0] CRC   = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        sdo, sen, latch, done;

  int          n_cmp = 0;
  int          n_err = 0;
  int          latch_total = 0;
  int          bit_total = 0;
  logic [31:0] cap = 32'h0;

  always #5 clk = ~clk;

  wb_cfg_stream_loader #(.FIFO_DEPTH(16), .BASE_ADDR(BASE), .BIT_DIV(1)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .cfg_sdo(sdo), .cfg_sen(sen), .cfg_latch(latch), .cfg_done(done)
  );

  always @(negedge clk) begin
    if (sen) begin
      cap       = {cap[30:0], sdo};
      bit_total = bit_total + 1;
    end
    if (latch) latch_total = latch_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r);
    logic got;
    got = 1'b0;
    r   = 32'h0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        r   = rdat;
        got = 1'b1;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) chk("ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'h0, r);
  endtask

  task automatic wait_done(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int          lbase, bbase;
    logic [3:0]  pat;
    logic        any_ack;

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = 32'h0; wdat = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",   32'(ack),   32'd0);
    chk("rst_sen",   32'(sen),   32'd0);
    chk("rst_latch", 32'(latch), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sdo",   32'(sdo),   32'd0);
    chk("rst_dat",   rdat,       32'h0);
    rst_n = 1'b1;
    rd(STAT, r); chk("rst_stat", r, 32'h0000_0004);
    rd(WCNT, r); chk("rst_wcnt", r, 32'h0);
    rd(CTRL, r); chk("ctrl_reads_zero", r, 32'h0);

    // single word stream
    lbase = latch_total; bbase = bit_total;
    wr(CTRL, 32'h1);
    wr(DATA, 32'hA5A5_0001);
    wr(CTRL, 32'h4);
    wait_done(200, "w1_done");
    chk("w1_bits",    cap, 32'hA5A5_0001);
    chk("w1_nbits",   32'(bit_total - bbase), 32'd32);
    chk("w1_latches", 32'(latch_total - lbase), 32'd1);
    rd(WCNT, r); chk("w1_wcnt", r, 32'd1);
    rd(STAT, r); chk("w1_stat", r, 32'h0000_000C);

    // overflow: fill while idle, 17th word is dropped
    for (int i = 0; i < 17; i++) wr(DATA, 32'h1000_0000 + 32'(i));
    rd(STAT, r); chk("ovf_stat", r, 32'h0000_101A);
    lbase = latch_total;
    wr(CTRL, 32'h1);
    rd(STAT, r); chk("ovf_cleared_busy", r & 32'h11, 32'h01);
    wr(CTRL, 32'h4);
    wait_done(800, "ovf_done");
    chk("ovf_latches", 32'(latch_total - lbase), 32'd16);
    chk("ovf_last_word", cap, 32'h1000_000F);
    rd(WCNT, r); chk("ovf_wcnt", r, 32'd16);

    // abort in the middle of the second word
    lbase = latch_total;
    wr(CTRL, 32'h1);
    for (int i = 0; i < 3; i++) wr(DATA, 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 200; i++) begin
      if (latch_total - lbase >= 1) break;
      @(posedge clk); #1;
    end
    chk("ab_first_latch", 32'(latch_total - lbase), 32'd1);
    repeat (5) @(posedge clk);
    wr(CTRL, 32'h2);
    chk("ab_sen_before", 32'(sen), 32'd1);
    @(posedge clk); #1;
    chk("ab_sen_after", 32'(sen), 32'd0);
    rd(STAT, r); chk("ab_stat", r, 32'h0000_0004);
    chk("ab_done", 32'(done), 32'd0);
    rd(WCNT, r); chk("ab_wcnt", r, 32'd1);
    repeat (40) @(posedge clk);
    chk("ab_no_more_latch", 32'(latch_total - lbase), 32'd1);

    // CRC over one zero word
    wr(CTRL, 32'h1);
    wr(DATA, 32'h0);
    wr(CTRL, 32'h4);
    wait_done(200, "crc_done");
    chk("crc_word", cap, 32'h0);
    rd(CRC, r);
`ifdef CFG_CRC_EN
    chk("crc_value", r, 32'h0000_84C0);
`else
    chk("crc_value", r, 32'h0);
`endif

    // back-to-back strobe held for four cycles
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = DATA; wdat = 32'h5555_AAAA;
    pat = 4'b0;
    for (int i = 0; i < 4; i++) begin
      pat = {pat[2:0], ack};
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("b2b_ack_pattern", 32'(pat), 32'h5);
    rd(STAT, r); chk("b2b_level", r, 32'h0000_0208);

    // unselected address is never acked
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h4000_0008; wdat = 32'h1;
    any_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      any_ack = any_ack | ack;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("unsel_no_ack", 32'(any_ack), 32'd0);
    rd(STAT, r); chk("unsel_level", r, 32'h0000_0208);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
